// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the cosine CORDIC request scheduler.
package cordic_sched_pkg;

    localparam int CORDIC_PIPE_LAT = 17;
    localparam int CORDIC_WORD_W   = 32;

    typedef logic req_id_t;

    typedef enum logic {
        FLUSH,
        RUN
    } sched_state_t;

    typedef struct packed {
        logic    valid;
        req_id_t tag;
    } tag_slot_t;

endpackage

// File: rtl/cordic_rsp_fifo.sv
// First-word-fall-through response FIFO; head reads as zero while empty.
module cordic_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; clearing the pointers and count hides stale words.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Credits upstream make this unreachable; firing means the accounting is broken.
    no_overflow: assert property (@(posedge clock) disable iff (!aclr_n) !(push && count == FULL_CNT));

endmodule

// File: rtl/cordic_scheduler.sv
// Two-requester round-robin front-end for the fixed-latency cosine CORDIC pipeline,
// with per-requester response FIFOs protected by credit accounting.
module cordic_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int PIPE_LAT   = CORDIC_PIPE_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [CORDIC_WORD_W-1:0] req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [CORDIC_WORD_W-1:0] req1_data,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [CORDIC_WORD_W-1:0] rsp0_data,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [CORDIC_WORD_W-1:0] rsp1_data,
    output logic                     pipe_aclr,
    output logic                     pipe_clk_en,
    output logic [CORDIC_WORD_W-1:0] pipe_dataa,
    input  logic [CORDIC_WORD_W-1:0] pipe_result,
    output logic                     busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    sched_state_t             state;
    logic                     flush_cnt;
    logic [1:0]               req_valid;
    logic [1:0]               rsp_ready;
    logic [1:0]               eligible;
    logic [1:0]               fifo_push;
    logic [1:0]               fifo_pop;
    logic [1:0]               fifo_empty;
    logic [CORDIC_WORD_W-1:0] req_data   [2];
    logic [CORDIC_WORD_W-1:0] fifo_head  [2];
    logic [CNT_W-1:0]         fifo_count [2];
    logic [CNT_W-1:0]         inflight   [2];
    req_id_t                  grant;
    req_id_t                  last_grant;
    logic                     issue;
    tag_slot_t                slots [PIPE_LAT];

    assign req_valid   = {req1_valid, req0_valid};
    assign rsp_ready   = {rsp1_ready, rsp0_ready};
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // A slot is free only if neither the FIFO nor the pipeline already owns it.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eligible[i]  = (state == RUN) && req_valid[i] &&
                           (({1'b0, fifo_count[i]} + {1'b0, inflight[i]}) < DEPTH_V);
            fifo_push[i] = slots[PIPE_LAT-1].valid && (slots[PIPE_LAT-1].tag == req_id_t'(i));
            fifo_pop[i]  = rsp_ready[i] && !fifo_empty[i];
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path drives grant and no latch is inferred.
        grant = 1'b0;
        if (&eligible) begin
            grant = ~last_grant;
        end else if (eligible[1]) begin
            grant = 1'b1;
        end
    end

    assign issue      = |eligible;
    assign req0_ready = issue && !grant;
    assign req1_ready = issue && grant;
    assign pipe_dataa = issue ? req_data[grant] : '0;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state       <= FLUSH;
            flush_cnt   <= 1'b0;
            pipe_aclr   <= 1'b1;
            pipe_clk_en <= 1'b0;
        end else begin
            case (state)
                FLUSH: begin
                    if (flush_cnt) begin
                        state       <= RUN;
                        pipe_aclr   <= 1'b0;
                        pipe_clk_en <= 1'b1;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= FLUSH;
                end
            endcase
        end
    end

    // Tag shadow of the pipeline; a stale valid after reset would push a phantom response.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                slots[k] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= '0;
            end
            last_grant <= 1'b1;
        end else if (state == RUN) begin
            slots[0] <= '{valid: issue, tag: grant};
            for (int k = 1; k < PIPE_LAT; k++) begin
                slots[k] <= slots[k-1];
            end
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= inflight[i]
                             + CNT_W'(issue && (grant == req_id_t'(i)))
                             - CNT_W'(fifo_push[i]);
            end
            if (issue) begin
                last_grant <= grant;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_rsp
        cordic_rsp_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (CORDIC_WORD_W)
        ) u_fifo (
            .clock     (clock),
            .aclr_n    (aclr_n),
            .push      (fifo_push[g]),
            .push_data (pipe_result),
            .pop       (fifo_pop[g]),
            .pop_data  (fifo_head[g]),
            .count     (fifo_count[g]),
            .empty     (fifo_empty[g])
        );
    end

    assign rsp0_valid = !fifo_empty[0];
    assign rsp1_valid = !fifo_empty[1];
    assign rsp0_data  = fifo_head[0];
    assign rsp1_data  = fifo_head[1];
    assign busy       = (inflight[0] != '0) || (inflight[1] != '0) || !(&fifo_empty);

endmodule

// File: tb/tb_cordic_scheduler.sv
// Self-checking bench: a queue-based scoreboard predicts every output each cycle,
// alongside directed checks with literal expectations.
module tb_cordic_scheduler;

    localparam int LAT   = 17;
    localparam int DEPTH = 4;

    logic        clock  = 1'b0;
    logic        aclr_n = 1'b1;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] req0_data, req1_data, rsp0_data, rsp1_data;
    logic        pipe_aclr, pipe_clk_en, busy;
    logic [31:0] pipe_dataa, pipe_result;

    int n_checks = 0;
    int n_errors = 0;
    int hs0_cnt  = 0;
    int hs1_cnt  = 0;

    always #5 clock = ~clock;

    cordic_scheduler #(
        .PIPE_LAT   (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_data   (rsp0_data),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_data   (rsp1_data),
        .pipe_aclr   (pipe_aclr),
        .pipe_clk_en (pipe_clk_en),
        .pipe_dataa  (pipe_dataa),
        .pipe_result (pipe_result),
        .busy        (busy)
    );

    // Stand-in pipeline result: exact cosines for the angles the plan names, a scramble otherwise.
    function automatic logic [31:0] cos_ref(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h3F80_0000;
            32'h3F00_0000: return 32'h3F60_A940;
            32'h3F80_0000: return 32'h3F0A_5140;
            default:       return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    logic [31:0] pipe_sr [LAT];
    always @(posedge clock) begin
        if (pipe_aclr) begin
            for (int i = 0; i < LAT; i++) pipe_sr[i] <= '0;
        end else if (pipe_clk_en) begin
            pipe_sr[0] <= cos_ref(pipe_dataa);
            for (int i = 1; i < LAT; i++) pipe_sr[i] <= pipe_sr[i-1];
        end
    end
    assign pipe_result = pipe_sr[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (aclr_n && req0_valid && req0_ready) hs0_cnt <= hs0_cnt + 1;
        if (aclr_n && req1_valid && req1_ready) hs1_cnt <= hs1_cnt + 1;
    end

    typedef struct {
        bit          tag;
        logic [31:0] res;
        int          due;
    } pend_t;

    // Scoreboard: pending results with their due edge, plus one queue per response FIFO.
    initial begin : model
        pend_t       m_pend [$];
        pend_t       p;
        logic [31:0] m_q0 [$];
        logic [31:0] m_q1 [$];
        int          m_edge;
        int          m_flush;
        bit          m_last;
        bit          run, hs, g;
        bit [1:0]    el;
        int          occ0, occ1, e;
        logic [31:0] exp_dataa;
        m_edge  = 0;
        m_flush = 0;
        m_last  = 1'b1;
        forever begin
            @(negedge clock);
            if (!aclr_n) begin
                m_pend.delete();
                m_q0.delete();
                m_q1.delete();
                m_flush = 0;
                m_last  = 1'b1;
                check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
                check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_pipe_ctl", {30'd0, pipe_aclr, pipe_clk_en}, 32'd2);
                check("rst_pipe_dataa", pipe_dataa, 32'd0);
                check("rst_rsp0_data", rsp0_data, 32'd0);
                check("rst_rsp1_data", rsp1_data, 32'd0);
            end else begin
                run  = (m_flush >= 2);
                occ0 = m_q0.size();
                occ1 = m_q1.size();
                foreach (m_pend[j]) begin
                    if (m_pend[j].tag) occ1++;
                    else occ0++;
                end
                el[0] = run && req0_valid && (occ0 < DEPTH);
                el[1] = run && req1_valid && (occ1 < DEPTH);
                hs    = |el;
                g     = (&el) ? ~m_last : el[1];
                exp_dataa = !hs ? 32'd0 : (g ? req1_data : req0_data);

                check("m_req0_ready", {31'd0, req0_ready}, {31'd0, hs && !g});
                check("m_req1_ready", {31'd0, req1_ready}, {31'd0, hs && g});
                check("m_pipe_dataa", pipe_dataa, exp_dataa);
                check("m_pipe_ctl", {30'd0, pipe_aclr, pipe_clk_en}, {30'd0, !run, run});
                check("m_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_q0.size() > 0});
                check("m_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_q1.size() > 0});
                if (m_q0.size() > 0) check("m_rsp0_data", rsp0_data, m_q0[0]);
                if (m_q1.size() > 0) check("m_rsp1_data", rsp1_data, m_q1[0]);
                check("m_busy", {31'd0, busy},
                      {31'd0, (m_pend.size() + m_q0.size() + m_q1.size()) > 0});

                e = m_edge + 1;
                if (m_q0.size() > 0 && rsp0_ready) void'(m_q0.pop_front());
                if (m_q1.size() > 0 && rsp1_ready) void'(m_q1.pop_front());
                while (m_pend.size() > 0 && m_pend[0].due == e) begin
                    p = m_pend.pop_front();
                    if (p.tag) m_q1.push_back(p.res);
                    else m_q0.push_back(p.res);
                end
                if (hs) begin
                    p.tag = g;
                    p.res = cos_ref(exp_dataa);
                    p.due = e + LAT;
                    m_pend.push_back(p);
                    m_last = g;
                end
                if (m_flush < 2) m_flush++;
                m_edge = e;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          base0, base1, sel;
        logic [31:0] a_op, b_op, c_op;
        {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = 4'b0;
        req0_data = '0;
        req1_data = '0;
        #1 aclr_n = 1'b0;
        repeat (3) tick();
        check("rst_busy_d", {31'd0, busy}, 32'd0);
        check("rst_aclr_d", {31'd0, pipe_aclr}, 32'd1);

        // Flush sequence and a single 0.0 request
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 32'h0;
        aclr_n     = 1'b1;
        tick();
        check("flush_e1_aclr", {31'd0, pipe_aclr}, 32'd1);
        check("flush_e1_en", {31'd0, pipe_clk_en}, 32'd0);
        check("flush_e1_ready", {31'd0, req0_ready}, 32'd0);
        tick();
        check("flush_e2_aclr", {31'd0, pipe_aclr}, 32'd0);
        check("flush_e2_en", {31'd0, pipe_clk_en}, 32'd1);
        check("run_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        check("single_hs", hs0_cnt, 32'd1);
        repeat (LAT - 1) tick();
        check("single_early", {31'd0, rsp0_valid}, 32'd0);
        tick();
        check("single_valid", {31'd0, rsp0_valid}, 32'd1);
        check("single_data", rsp0_data, 32'h3F80_0000);
        check("single_rsp1", {31'd0, rsp1_valid}, 32'd0);
        tick();
        check("single_popped", {31'd0, rsp0_valid}, 32'd0);

        // Round-robin; requester 0 took the last grant, so requester 1 wins the first tie
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        req0_data  = 32'h3F00_0000;
        req1_data  = 32'h3F80_0000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("rr_ready0", {31'd0, req0_ready}, {31'd0, (i % 2) == 1});
            check("rr_ready1", {31'd0, req1_ready}, {31'd0, (i % 2) == 0});
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (LAT + 1) tick();
        for (int i = 0; i < DEPTH; i++) begin
            check("rr_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            check("rr_rsp0_data", rsp0_data, 32'h3F60_A940);
            rsp0_ready = 1'b1;
            tick();
            rsp0_ready = 1'b0;
        end
        check("rr_rsp0_empty", {31'd0, rsp0_valid}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check("rr_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            check("rr_rsp1_data", rsp1_data, 32'h3F0A_5140);
            rsp1_ready = 1'b1;
            tick();
            rsp1_ready = 1'b0;
        end
        check("rr_rsp1_empty", {31'd0, rsp1_valid}, 32'd0);

        // Backpressure: requester 0's consumer stalls, requester 1 keeps flowing
        base0      = hs0_cnt;
        base1      = hs1_cnt;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            req0_data = $urandom;
            req1_data = $urandom;
            tick();
        end
        check("bp_hs0", hs0_cnt - base0, 32'd4);
        check("bp_ready0_low", {31'd0, req0_ready}, 32'd0);
        check("bp_req1_served", {31'd0, (hs1_cnt - base1) > 0}, 32'd1);
        req1_valid = 1'b0;
        tick();
        base0      = hs0_cnt;
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("bp_ready_after_pop", {31'd0, req0_ready}, 32'd1);
        repeat (25) tick();
        check("bp_one_more", hs0_cnt - base0, 32'd1);
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        repeat (LAT + 8) tick();

        // Result lands on the same edge as a pop with two entries held
        rsp0_ready = 1'b0;
        a_op = 32'h1111_1111;
        b_op = 32'h2222_2222;
        c_op = 32'h3333_3333;
        req0_valid = 1'b1;
        req0_data  = a_op;
        tick();
        req0_data = b_op;
        tick();
        req0_valid = 1'b0;
        repeat (LAT + 2) tick();
        check("wp_head_a", rsp0_data, cos_ref(a_op));
        req0_valid = 1'b1;
        req0_data  = c_op;
        #1;
        check("wp_issue_c", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        repeat (LAT - 1) tick();
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("wp_head_b", rsp0_data, cos_ref(b_op));
        rsp0_ready = 1'b1;
        tick();
        check("wp_head_c", rsp0_data, cos_ref(c_op));
        tick();
        rsp0_ready = 1'b0;
        check("wp_drained", {31'd0, rsp0_valid}, 32'd0);

        // Randomised traffic, first with eager consumers, then with sluggish ones
        for (int phase = 0; phase < 2; phase++) begin
            repeat (1500) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req1_valid = ($urandom_range(0, 2) != 0);
                sel        = $urandom_range(0, 3);
                req0_data  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h3F00_0000 : $urandom;
                sel        = $urandom_range(0, 3);
                req1_data  = (sel == 0) ? 32'h3F80_0000 : $urandom;
                rsp0_ready = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                rsp1_ready = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
                tick();
            end
        end

        // Reset with operations in flight and results queued
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (LAT + 8) tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (20) tick();
        check("mf_busy_before", {31'd0, busy}, 32'd1);
        check("mf_rsp0_before", {31'd0, rsp0_valid}, 32'd1);
        aclr_n = 1'b0;
        #1;
        check("mf_rsp_valid_now", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("mf_busy_now", {31'd0, busy}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) tick();
        aclr_n     = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("mf_no_stale", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
